// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array sequencer.
// sa_array_ctrl and sa_skew_mask both import this package.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOADB,
        RUN,
        FIN,
        ABRT
    } sa_state_e;

    localparam int SA_N      = 4;
    localparam int SA_MW     = 8;
    localparam int SA_PE_LAT = 7;

    // Never returns 0, so a 1x1 array still gets a 1-bit row address.
    function automatic int sa_clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sa_skew_mask.sv
// Lane k of the skewed A feed carries vector t-k, so it is live for k <= t < k+M.
// Purely combinational; the A-feeder uses the same block.
module sa_skew_mask
    import sa_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int MW = SA_MW
) (
    input  logic [MW:0]   step,
    input  logic [MW-1:0] m_len,
    output logic [N-1:0]  lane_valid
);

    localparam int SW = MW + 1;

    // The comparison is done in MW+1 bits so that t-k can never wrap.
    always_comb begin
        lane_valid = '0;
        for (int k = 0; k < N; k++) begin
            lane_valid[k] = (step >= SW'(k)) && ((step - SW'(k)) < {1'b0, m_len});
        end
    end

endmodule

// File: rtl/sa_array_ctrl.sv
// Job sequencer for the N x N systolic array: clear, load B, stream skewed A, then drain.
// Every output is registered and is computed from the next state, so it lines up with state_q.
module sa_array_ctrl
    import sa_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int MW     = SA_MW,
    parameter int PE_LAT = SA_PE_LAT,
    localparam int RW    = sa_clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [MW-1:0] m_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          err_len,
    output logic          data_clear,
    output logic [N-1:0]  b_we,
    output logic [RW-1:0] b_row,
    output logic          en_shift_right,
    output logic          en_shift_bottom,
    output logic [MW:0]   a_step,
    output logic [N-1:0]  a_lane_valid,
    output logic          out_valid,
    output logic [MW:0]   out_step
);

    localparam int SW = MW + 1;
    localparam logic [SW-1:0] OUT_OFS  = SW'(PE_LAT + N);
    localparam logic [SW-1:0] N_S      = SW'(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    sa_state_e     state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [SW-1:0] step_q, step_d;
    logic [MW-1:0] m_q, m_d;

    logic [SW-1:0] m_ext, t_end, rel_t;
    logic [N-1:0]  lane_mask;

    logic          busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic          err_len_q, err_len_d, clear_q, clear_d, shift_q, shift_d;
    logic [N-1:0]  b_we_q, b_we_d, lanes_q, lanes_d;
    logic [RW-1:0] b_row_q, b_row_d;
    logic [SW-1:0] a_step_q, a_step_d, out_step_q, out_step_d;
    logic          out_valid_q, out_valid_d;

    assign m_ext = {1'b0, m_q};
    assign t_end = OUT_OFS + m_ext + N_S - SW'(2);
    assign rel_t = step_d - OUT_OFS;

    sa_skew_mask #(.N(N), .MW(MW)) u_skew (
        .step       (step_d),
        .m_len      (m_q),
        .lane_valid (lane_mask)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = '0;
        step_d    = '0;
        m_d       = m_q;
        err_len_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (m_len != '0) begin
                        m_d     = m_len;
                        state_d = CLR;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            CLR:   state_d = LOADB;
            LOADB: begin
                if (row_q == LAST_ROW) state_d = RUN;
                else                   row_d   = row_q + RW'(1);
            end
            RUN: begin
                if (step_q == t_end) state_d = FIN;
                else                 step_d  = step_q + SW'(1);
            end
            FIN:     state_d = IDLE;
            ABRT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides every other transition; a job that is still idle cannot be aborted.
        if (abort && (state_q != IDLE) && (state_q != ABRT)) begin
            state_d = ABRT;
            row_d   = '0;
            step_d  = '0;
        end

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
        aborted_d   = (state_d == ABRT);
        clear_d     = (state_d == CLR) || (state_d == ABRT);
        shift_d     = (state_d == RUN);
        b_we_d      = (state_d == LOADB) ? (N'(1) << row_d) : '0;
        b_row_d     = (state_d == LOADB) ? row_d : '0;
        a_step_d    = (state_d == RUN) ? step_d : '0;
        lanes_d     = (state_d == RUN) ? lane_mask : '0;
        out_valid_d = (state_d == RUN) && (step_d >= OUT_OFS) &&
                      (rel_t < (m_ext + N_S - SW'(1)));
        out_step_d  = out_valid_d ? rel_t : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            step_q      <= '0;
            m_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_len_q   <= 1'b0;
            clear_q     <= 1'b0;
            shift_q     <= 1'b0;
            b_we_q      <= '0;
            b_row_q     <= '0;
            a_step_q    <= '0;
            lanes_q     <= '0;
            out_valid_q <= 1'b0;
            out_step_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            step_q      <= step_d;
            m_q         <= m_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            err_len_q   <= err_len_d;
            clear_q     <= clear_d;
            shift_q     <= shift_d;
            b_we_q      <= b_we_d;
            b_row_q     <= b_row_d;
            a_step_q    <= a_step_d;
            lanes_q     <= lanes_d;
            out_valid_q <= out_valid_d;
            out_step_q  <= out_step_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign err_len         = err_len_q;
    assign data_clear      = clear_q;
    assign b_we            = b_we_q;
    assign b_row           = b_row_q;
    assign en_shift_right  = shift_q;
    assign en_shift_bottom = shift_q;
    assign a_step          = a_step_q;
    assign a_lane_valid    = lanes_q;
    assign out_valid       = out_valid_q;
    assign out_step        = out_step_q;

endmodule

// File: tb/tb_sa_array_ctrl.sv
// Directed table-driven bench for sa_array_ctrl with N=4, MW=8, PE_LAT=7 (so OUT_OFS=11).
// Each cycle checks the outputs against a hand-written job table; a feed model also checks the identity-B matmul.
module tb_sa_array_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] m_len = 8'd0;
    logic       abort = 1'b0;

    logic       busy, done, aborted, err_len, data_clear;
    logic [3:0] b_we;
    logic [1:0] b_row;
    logic       en_shift_right, en_shift_bottom;
    logic [8:0] a_step;
    logic [3:0] a_lane_valid;
    logic       out_valid;
    logic [8:0] out_step;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sa_array_ctrl #(.N(4), .MW(8), .PE_LAT(7)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .m_len           (m_len),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .err_len         (err_len),
        .data_clear      (data_clear),
        .b_we            (b_we),
        .b_row           (b_row),
        .en_shift_right  (en_shift_right),
        .en_shift_bottom (en_shift_bottom),
        .a_step          (a_step),
        .a_lane_valid    (a_lane_valid),
        .out_valid       (out_valid),
        .out_step        (out_step)
    );

    typedef struct {
        logic       start;
        logic [7:0] m_len;
        logic       abort;
        logic       busy, done, aborted, err_len, clr;
        logic [3:0] bwe;
        logic [1:0] brow;
        logic       sh;
        logic [8:0] astep;
        logic [3:0] lanes;
        logic       ov;
        logic [8:0] ostep;
    } vec_t;

    localparam int JOB_ROWS = 24;
    localparam logic [35:0] ALL_ZERO = '0;

    vec_t job_tbl [JOB_ROWS];

    // A is 3x4, B is the identity, so the reference product equals A.
    int a_mat [3][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}};
    int b_mat [4][4] = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
    int c_ref [3][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}};
    int fed_val [3][4];
    bit mon_en = 1'b0;

    function automatic vec_t ctl_v(input logic bsy, input logic dn, input logic ab,
                                   input logic er, input logic cl,
                                   input logic [3:0] bwe, input logic [1:0] brow);
        vec_t v;
        v.start = 1'b0; v.m_len = 8'd0; v.abort = 1'b0;
        v.busy = bsy; v.done = dn; v.aborted = ab; v.err_len = er; v.clr = cl;
        v.bwe = bwe; v.brow = brow; v.sh = 1'b0; v.astep = 9'd0;
        v.lanes = 4'b0000; v.ov = 1'b0; v.ostep = 9'd0;
        return v;
    endfunction

    function automatic vec_t run_v(input logic [8:0] t, input logic [3:0] ln,
                                   input logic ov, input logic [8:0] os);
        vec_t v;
        v = ctl_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0);
        v.sh = 1'b1; v.astep = t; v.lanes = ln; v.ov = ov; v.ostep = os;
        return v;
    endfunction

    function automatic logic [35:0] pack(input vec_t v);
        return {v.busy, v.done, v.aborted, v.err_len, v.clr, v.bwe, v.brow, v.sh, v.sh,
                v.astep, v.lanes, v.ov, v.ostep};
    endfunction

    task automatic applyStimulus(input logic s, input logic [7:0] m, input logic a);
        @(negedge clk);
        start = s;
        m_len = m;
        abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [35:0] exp_v);
        logic [35:0] got;
        got = {busy, done, aborted, err_len, data_clear, b_we, b_row, en_shift_right,
               en_shift_bottom, a_step, a_lane_valid, out_valid, out_step};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp_v);
        end
    endtask

    // Replays the m_len=3 job table; optionally holds start high while busy or raises abort with the start.
    task automatic run_job(input int last_row, input bit force_start, input bit start_abort);
        logic       s;
        logic [7:0] m;
        logic       a;
        for (int i = 0; i <= last_row; i++) begin
            s = job_tbl[i].start;
            m = job_tbl[i].m_len;
            a = job_tbl[i].abort;
            if (force_start && i > 0) begin
                s = 1'b1;
                m = 8'd7;
            end
            if (start_abort && i == 0) a = 1'b1;
            applyStimulus(s, m, a);
            checkOutput($sformatf("job_row_%0d", i), pack(job_tbl[i]));
        end
    endtask

    // Host-side model: feed A[t-k][k] on each live lane, then rebuild each column sum when the controller flags it valid.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                if (a_lane_valid[k]) begin
                    int v;
                    v = int'(a_step) - k;
                    n_checks++;
                    if (v < 0 || v >= 3) begin
                        n_fail++;
                        $display("[TB] FAIL lane_range: lane %0d at t=%0d gives vector %0d, required 0..2", k, a_step, v);
                    end else begin
                        fed_val[v][k] = a_mat[v][k];
                    end
                end
            end
            if (out_valid) begin
                for (int j = 0; j < 4; j++) begin
                    int v;
                    int sum;
                    v = int'(out_step) - j;
                    if (v >= 0 && v < 3) begin
                        sum = 0;
                        for (int k = 0; k < 4; k++) sum += fed_val[v][k] * b_mat[k][j];
                        n_checks++;
                        if (sum != c_ref[v][j]) begin
                            n_fail++;
                            $display("[TB] FAIL colsum: col %0d vec %0d got %0d required %0d", j, v, sum, c_ref[v][j]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Job with m_len=3: T_END = 11+3+4-2 = 16, out_valid for t=11..16 (steps 0..5).
        job_tbl[0]  = ctl_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0);
        job_tbl[0].start = 1'b1;
        job_tbl[0].m_len = 8'd3;
        job_tbl[1]  = ctl_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0);
        job_tbl[2]  = ctl_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1);
        job_tbl[3]  = ctl_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2);
        job_tbl[4]  = ctl_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3);
        job_tbl[5]  = run_v(9'd0,  4'b0001, 1'b0, 9'd0);
        job_tbl[6]  = run_v(9'd1,  4'b0011, 1'b0, 9'd0);
        job_tbl[7]  = run_v(9'd2,  4'b0111, 1'b0, 9'd0);
        job_tbl[8]  = run_v(9'd3,  4'b1110, 1'b0, 9'd0);
        job_tbl[9]  = run_v(9'd4,  4'b1100, 1'b0, 9'd0);
        job_tbl[10] = run_v(9'd5,  4'b1000, 1'b0, 9'd0);
        job_tbl[11] = run_v(9'd6,  4'b0000, 1'b0, 9'd0);
        job_tbl[12] = run_v(9'd7,  4'b0000, 1'b0, 9'd0);
        job_tbl[13] = run_v(9'd8,  4'b0000, 1'b0, 9'd0);
        job_tbl[14] = run_v(9'd9,  4'b0000, 1'b0, 9'd0);
        job_tbl[15] = run_v(9'd10, 4'b0000, 1'b0, 9'd0);
        job_tbl[16] = run_v(9'd11, 4'b0000, 1'b1, 9'd0);
        job_tbl[17] = run_v(9'd12, 4'b0000, 1'b1, 9'd1);
        job_tbl[18] = run_v(9'd13, 4'b0000, 1'b1, 9'd2);
        job_tbl[19] = run_v(9'd14, 4'b0000, 1'b1, 9'd3);
        job_tbl[20] = run_v(9'd15, 4'b0000, 1'b1, 9'd4);
        job_tbl[21] = run_v(9'd16, 4'b0000, 1'b1, 9'd5);
        job_tbl[22] = ctl_v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0);
        job_tbl[23] = ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_state", ALL_ZERO);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("idle_%0d", i), ALL_ZERO);
        end

        for (int v = 0; v < 3; v++)
            for (int k = 0; k < 4; k++) fed_val[v][k] = 0;
        mon_en = 1'b1;
        run_job(JOB_ROWS - 1, 1'b0, 1'b0);
        mon_en = 1'b0;

        applyStimulus(1'b1, 8'd0, 1'b0);
        checkOutput("err_len_pulse", pack(ctl_v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0)));
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("err_len_clear", ALL_ZERO);
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("abort_in_idle", ALL_ZERO);

        run_job(JOB_ROWS - 1, 1'b1, 1'b0);
        run_job(JOB_ROWS - 1, 1'b0, 1'b1);

        run_job(10, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("abort_state", pack(ctl_v(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0)));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("after_abort_%0d", i), ALL_ZERO);
        end

        run_job(3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", ALL_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(JOB_ROWS - 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
